mul_req_ctrl: RTL
=================

# mul_req_ctrl

Request/response front-end for the RV32M multiply path. It accepts MUL/MULH/MULHSU/MULHU requests from the execute stage and sign/zero-extends the 32-bit operands to the multiplier core's 34-bit width. It launches the team's iterative radix-4 Booth multiplier core, captures the 68-bit product on its finish pulse, and returns the selected 32-bit half to writeback through a valid/ready handshake. It sits directly upstream of the multiplier core, drives its `start` and operand inputs, and consumes its `result` and `mulfinish` outputs.

## Interface
- `XLEN`, 32, architectural operand width.
- `MDW`, `XLEN+2`, multiplier core operand width. Must equal the core's `DW`.
- `clk`  in  1  clock. All state is updated on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept a request.
- `req_op`  in  2  operation: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
- `req_rs1`, `req_rs2`  in  XLEN  source operands.
- `req_rd`  in  5  destination tag, returned unchanged.
- `flush`  in  1  kill the in-flight or pending operation.
- `mul_start`  out  1  single-cycle start pulse to the core.
- `mul_multiplier`  out  MDW  extended rs1.
- `mul_multiplicand`  out  MDW  extended rs2.
- `mul_result`  in  2*MDW  core product.
- `mul_finish`  in  1  core done pulse. `mul_result` is valid only in this cycle.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  writeback accepts the response.
- `rsp_data`  out  XLEN  result.
- `rsp_rd`  out  5  destination tag.

## Operation
- FSM states: IDLE, START, BUSY, RESP, DRAIN. Reset state is IDLE.
- `req_ready` = (state==IDLE) & ~`flush` & ~`rst`.
- **IDLE**
  - Handshake (`req_valid` & `req_ready`) latches `op`, `rs1`, `rs2`, `rd` and moves to START.
- **START**
  - `mul_start`=1 for exactly this cycle.
  - Next state is BUSY, or DRAIN if `flush` is asserted.
- **BUSY**
  - On `mul_finish`, capture `mul_result` and move to RESP.
  - If `flush` is asserted, move to DRAIN. If `flush` and `mul_finish` coincide, discard the result and go to IDLE.
- **RESP**
  - `rsp_valid`=1; `rsp_data` and `rsp_rd` are held stable.
  - On `rsp_ready`, go to IDLE.
  - If `flush` is asserted, go to IDLE and drop the response.
- **DRAIN**
  - The core cannot be aborted. Wait for `mul_finish`, discard the result, go to IDLE.
  - `flush` has no further effect in this state.
- `mul_multiplier` and `mul_multiplicand` are driven from the latched operands and stay stable from START through BUSY.
- Operand extension:
  - signed operand: {op[XLEN-1], op[XLEN-1], op}
  - unsigned operand: {2'b00, op}
- Per-op signedness (rs1/rs2):
  - MUL s/s
  - MULH s/s
  - MULHSU s/u
  - MULHU u/u
- Result selection:
  - MUL takes `mul_result[XLEN-1:0]`.
  - MULH, MULHSU and MULHU take `mul_result[2*XLEN-1:XLEN]`.
- Never asserts `mul_start` while the core is active.
- No assumption is made about core latency; the block waits for `mul_finish`.

## Timing
- Reset values: `req_ready`=0 while `rst` is high, then 1. `mul_start`, `rsp_valid`=0. All data outputs =0.
- Nominal core timing:
  - Handshake in cycle A.
  - `mul_start` in cycle A+1.
  - `mul_finish` in cycle A+19.
  - `rsp_valid` from cycle A+20.
- Minimum spacing between accepted uncached requests is 21 cycles.
- `rsp_valid` never deasserts without `rsp_ready`, except on `flush` or reset.
- Reset mid-operation returns the FSM to IDLE immediately. The core must be reset by the same `rst`.

## Configuration
- `MUL_RESULT_CACHE_EN`
  - **Defined:** a one-entry cache holds the last full product with its `rs1`, `rs2` and signedness pair, plus a valid bit.
    - Filled on every BUSY capture. Drained and flushed results are not cached.
    - Valid bit is cleared by reset only.
    - A request in IDLE whose operands and signedness match the entry goes directly to RESP: `rsp_valid` in cycle A+1, no `mul_start`.
  - **Undefined:** no cache is built. Every request runs the core.

## Test plan
- MUL, rs1=3, rs2=5 -> `rsp_data`=0x0000000F, `rsp_rd` echoed, `rsp_valid` at A+20.
- MULH 0x80000000×0x80000000 -> 0x40000000. MULHSU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFF. MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE.
- `rsp_ready` held low for 10 cycles in RESP -> `rsp_data` stable, `req_ready`=0, then a single response is delivered.
- `flush` in BUSY at A+5 -> DRAIN; no `rsp_valid`; `req_ready` returns the cycle after `mul_finish`; next request gives the correct result.
- `flush` in START -> DRAIN, one `mul_start` only. `flush` coinciding with `mul_finish` -> IDLE, no response.
- With `MUL_RESULT_CACHE_EN`:
  - MULH 0x7FFFFFFF×0x7FFFFFFF -> 0x3FFFFFFF.
  - Then MUL with the same operands -> 0x00000001 at A+1, no `mul_start`.
  - Then MULHU with the same operands -> full core run.

Source files
------------

// File: rtl/mul_req_ctrl.sv
// rtl/mul_req_ctrl.sv - RV32M multiply request/response front-end (optional MUL_RESULT_CACHE_EN)
module mul_req_ctrl #(
  parameter int XLEN = 32,
  parameter int MDW  = XLEN + 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [XLEN-1:0]  req_rs1,
  input  logic [XLEN-1:0]  req_rs2,
  input  logic [4:0]       req_rd,
  input  logic             flush,
  output logic             mul_start,
  output logic [MDW-1:0]   mul_multiplier,
  output logic [MDW-1:0]   mul_multiplicand,
  input  logic [2*MDW-1:0] mul_result,
  input  logic             mul_finish,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [XLEN-1:0]  rsp_data,
  output logic [4:0]       rsp_rd
);

  typedef enum logic [2:0] {IDLE, START, BUSY, RESP, DRAIN} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [1:0]      op_q;
  logic [XLEN-1:0] rs1_q;
  logic [XLEN-1:0] rs2_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] data_q;
  logic            s1_q;
  logic            s2_q;
  logic            accept;
  logic            capture;
  logic            hit;
  logic [XLEN-1:0] hit_data;
  logic            unused_result_hi;

  // MUL returns the low word, every other op returns the high word
  function automatic logic [XLEN-1:0] sel_half(input logic [1:0] op, input logic [2*XLEN-1:0] prod);
    sel_half = (op == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  endfunction

  // The core's top bits only repeat the sign of the 64-bit product
  assign unused_result_hi = ^mul_result[2*MDW-1:2*XLEN];

  assign req_ready = (state == IDLE) & ~flush & ~rst;
  assign accept    = req_valid & req_ready;
  assign capture   = (state == BUSY) & mul_finish & ~flush;

  // rs1 is signed for all ops except MULHU; rs2 only for MUL/MULH
  assign s1_q = (op_q != 2'b11);
  assign s2_q = ~op_q[1];

  assign mul_multiplier   = {{(MDW-XLEN){rs1_q[XLEN-1] & s1_q}}, rs1_q};
  assign mul_multiplicand = {{(MDW-XLEN){rs2_q[XLEN-1] & s2_q}}, rs2_q};
  assign rsp_data         = data_q;
  assign rsp_rd           = rd_q;

`ifdef MUL_RESULT_CACHE_EN
  logic              c_valid;
  logic [XLEN-1:0]   c_rs1;
  logic [XLEN-1:0]   c_rs2;
  logic              c_s1;
  logic              c_s2;
  logic [2*XLEN-1:0] c_prod;
  logic              s1_req;
  logic              s2_req;

  assign s1_req   = (req_op != 2'b11);
  assign s2_req   = ~req_op[1];
  assign hit      = c_valid & (c_rs1 == req_rs1) & (c_rs2 == req_rs2) &
                    (c_s1 == s1_req) & (c_s2 == s2_req);
  assign hit_data = sel_half(req_op, c_prod);

  // One-entry product cache, refreshed on every result that reaches RESP from the core
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_valid <= 1'b0;
      c_rs1   <= '0;
      c_rs2   <= '0;
      c_s1    <= 1'b0;
      c_s2    <= 1'b0;
      c_prod  <= '0;
    end else if (capture) begin
      c_valid <= 1'b1;
      c_rs1   <= rs1_q;
      c_rs2   <= rs2_q;
      c_s1    <= s1_q;
      c_s2    <= s2_q;
      c_prod  <= mul_result[2*XLEN-1:0];
    end
  end
`else
  assign hit      = 1'b0;
  assign hit_data = '0;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and handshake outputs
  always_comb begin
    state_nxt = state;
    mul_start = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_nxt = hit ? RESP : START;
      end
      START: begin
        mul_start = 1'b1;
        state_nxt = flush ? DRAIN : BUSY;
      end
      BUSY: begin
        if (flush)           state_nxt = mul_finish ? IDLE : DRAIN;
        else if (mul_finish) state_nxt = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (flush | rsp_ready) state_nxt = IDLE;
      end
      DRAIN: begin
        if (mul_finish) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Latch the accepted request; operands and tag stay put until the next accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q  <= '0;
      rs1_q <= '0;
      rs2_q <= '0;
      rd_q  <= '0;
    end else if (accept) begin
      op_q  <= req_op;
      rs1_q <= req_rs1;
      rs2_q <= req_rs2;
      rd_q  <= req_rd;
    end
  end

  // Response word, loaded from the core's finish cycle or from a cache hit
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                data_q <= '0;
    else if (capture)       data_q <= sel_half(op_q, mul_result[2*XLEN-1:0]);
    else if (accept & hit)  data_q <= hit_data;
  end

endmodule
